// File: rtl/inst_fetch_ctrl.sv
// +--------------------------------------------------------------------------+
// | Module      : inst_fetch_ctrl                                            |
// | Description : PC owner, ROM address driver and prefetch queue feeding    |
// |               decode over valid/ready; flushes on redirect.              |
// |               Optional J/JAL predecode: FETCH_JUMP_PREDECODE_EN          |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
`default_nettype none

module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] Address,
  input  logic [31:0] Instruction,
  output logic        IF_Valid,
  output logic [31:0] IF_Instruction,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_PCPlus4,
  output logic        IF_PredTaken,
  input  logic        ID_Ready,
  input  logic        RedirectValid,
  input  logic [31:0] RedirectTarget,
  output logic        Misalign
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(DEPTH + 1);

  logic [31:0]        r_pc;
  logic [c_CNT_W-1:0] r_count;
  logic [c_PTR_W-1:0] r_head;
  logic [c_PTR_W-1:0] r_tail;
  logic               r_misalign;

  logic [31:0]        r_q_pc   [DEPTH];
  logic [31:0]        r_q_inst [DEPTH];
  logic               r_q_pred [DEPTH];

  logic               w_valid;
  logic               w_pop;
  logic               w_push;
  logic [31:0]        w_pc_plus4;
  logic [31:0]        w_next_pc;
  logic               w_pred;

  assign w_valid    = (r_count != '0);
  assign w_pop      = w_valid & ID_Ready;
  assign w_push     = ((r_count < c_CNT_W'(DEPTH)) | w_pop) & ~RedirectValid;
  assign w_pc_plus4 = r_pc + 32'd4;

`ifdef FETCH_JUMP_PREDECODE_EN
  // Only direct J/JAL are resolvable here; JR needs a register value.
  logic w_is_jump;
  assign w_is_jump = (Instruction[31:26] == 6'h02) | (Instruction[31:26] == 6'h03);
  assign w_next_pc = w_is_jump ? {w_pc_plus4[31:28], Instruction[25:0], 2'b00} : w_pc_plus4;
  assign w_pred    = w_is_jump;
`else
  assign w_next_pc = w_pc_plus4;
  assign w_pred    = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc       <= RESET_PC;
      r_count    <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= RedirectValid & (|RedirectTarget[1:0]);
      // Redirect wins over any push/pop; the head offered this cycle is dropped.
      if (RedirectValid) begin
        r_pc    <= {RedirectTarget[31:2], 2'b00};
        r_count <= '0;
        r_head  <= '0;
        r_tail  <= '0;
      end else begin
        if (w_push) begin
          r_pc   <= w_next_pc;
          r_tail <= r_tail + c_PTR_W'(1);
        end
        if (w_pop) begin
          r_head <= r_head + c_PTR_W'(1);
        end
        r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
      end
    end
  end

  // Payload storage needs no reset: outputs are gated by the valid count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_pc[r_tail]   <= r_pc;
      r_q_inst[r_tail] <= Instruction;
      r_q_pred[r_tail] <= w_pred;
    end
  end

  assign Address        = r_pc;
  assign IF_Valid       = w_valid;
  assign IF_Instruction = w_valid ? r_q_inst[r_head] : 32'd0;
  assign IF_PC          = w_valid ? r_q_pc[r_head] : 32'd0;
  assign IF_PCPlus4     = w_valid ? (r_q_pc[r_head] + 32'd4) : 32'd0;
  assign IF_PredTaken   = w_valid & r_q_pred[r_head];
  assign Misalign       = r_misalign;

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_ctrl.sv
// +--------------------------------------------------------------------------+
// | Module      : tb_inst_fetch_ctrl                                         |
// | Description : Directed self-checking bench for inst_fetch_ctrl.          |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_inst_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] Instruction;
  logic        IF_Valid;
  logic [31:0] IF_Instruction;
  logic [31:0] IF_PC;
  logic [31:0] IF_PCPlus4;
  logic        IF_PredTaken;
  logic        ID_Ready;
  logic        RedirectValid;
  logic [31:0] RedirectTarget;
  logic        Misalign;

  int checks = 0;
  int errors = 0;

  inst_fetch_ctrl #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .Address        (Address),
    .Instruction    (Instruction),
    .IF_Valid       (IF_Valid),
    .IF_Instruction (IF_Instruction),
    .IF_PC          (IF_PC),
    .IF_PCPlus4     (IF_PCPlus4),
    .IF_PredTaken   (IF_PredTaken),
    .ID_Ready       (ID_Ready),
    .RedirectValid  (RedirectValid),
    .RedirectTarget (RedirectTarget),
    .Misalign       (Misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ROM; unlisted words are addi encodings (never J/JAL).
  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h0000_0000: rom = 32'h0000_2821;
      32'h0000_0004: rom = 32'h20a4_0004;
      32'h0000_000C: rom = 32'h0c10_006d;
      default:       rom = 32'h2000_0000 | {16'h0, a[15:0]};
    endcase
  endfunction

  assign Instruction = rom(Address);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

`ifdef FETCH_JUMP_PREDECODE_EN
  // {PC+4[31:28]=0, 26'h010006d, 2'b00}
  localparam logic [31:0] c_JAL_NEXT = 32'h0040_01B4;
  localparam logic [31:0] c_JAL_PRED = 32'd1;
`else
  localparam logic [31:0] c_JAL_NEXT = 32'h0000_0010;
  localparam logic [31:0] c_JAL_PRED = 32'd0;
`endif

  initial begin
    reset          = 1'b0;
    ID_Ready       = 1'b0;
    RedirectValid  = 1'b0;
    RedirectTarget = 32'h0;

    // Reset state
    tick;
    tick;
    check("rst_valid",   {31'h0, IF_Valid},     32'd0);
    check("rst_addr",    Address,               32'h0);
    check("rst_inst",    IF_Instruction,        32'h0);
    check("rst_pc",      IF_PC,                 32'h0);
    check("rst_pcp4",    IF_PCPlus4,            32'h0);
    check("rst_pred",    {31'h0, IF_PredTaken}, 32'd0);
    check("rst_misal",   {31'h0, Misalign},     32'd0);

    // Release: streaming with ID_Ready=1
    reset    = 1'b1;
    ID_Ready = 1'b1;
    tick;
    check("s0_valid",    {31'h0, IF_Valid},     32'd1);
    check("s0_pc",       IF_PC,                 32'h0);
    check("s0_inst",     IF_Instruction,        32'h0000_2821);
    check("s0_pcp4",     IF_PCPlus4,            32'h4);
    check("s0_addr",     Address,               32'h4);
    tick;
    check("s1_pc",       IF_PC,                 32'h4);
    check("s1_inst",     IF_Instruction,        32'h20a4_0004);
    tick;
    check("s2_pc",       IF_PC,                 32'h8);
    check("s2_addr",     Address,               32'hC);

    // Restart at 0 with decode stalled; queue saturates at two
    ID_Ready       = 1'b0;
    RedirectValid  = 1'b1;
    RedirectTarget = 32'h0;
    tick;
    check("st_flush_v",  {31'h0, IF_Valid},     32'd0);
    check("st_flush_a",  Address,               32'h0);
    RedirectValid = 1'b0;
    tick;
    check("st1_addr",    Address,               32'h4);
    tick;
    check("st2_addr",    Address,               32'h8);
    tick;
    tick;
    tick;
    check("st_frz_addr", Address,               32'h8);
    check("st_frz_pc",   IF_PC,                 32'h0);
    check("st_frz_v",    {31'h0, IF_Valid},     32'd1);

    // Drain: 0 is consumed on the next edge, then 4, then 8
    ID_Ready = 1'b1;
    tick;
    check("dr_pc4",      IF_PC,                 32'h4);
    check("dr_addr",     Address,               32'hC);
    tick;
    check("dr_pc8",      IF_PC,                 32'h8);

    // Redirect while full and ready
    RedirectValid  = 1'b1;
    RedirectTarget = 32'h0000_01B4;
    tick;
    check("rd_valid",    {31'h0, IF_Valid},     32'd0);
    check("rd_addr",     Address,               32'h1B4);
    check("rd_misal",    {31'h0, Misalign},     32'd0);
    RedirectValid = 1'b0;
    tick;
    check("rd2_valid",   {31'h0, IF_Valid},     32'd1);
    check("rd2_pc",      IF_PC,                 32'h1B4);
    check("rd2_pcp4",    IF_PCPlus4,            32'h1B8);
    check("rd2_misal",   {31'h0, Misalign},     32'd0);

    // Misaligned redirect
    RedirectValid  = 1'b1;
    RedirectTarget = 32'h0000_0106;
    tick;
    check("ma_addr",     Address,               32'h104);
    check("ma_pulse",    {31'h0, Misalign},     32'd1);
    check("ma_valid",    {31'h0, IF_Valid},     32'd0);
    RedirectValid = 1'b0;
    tick;
    check("ma_clear",    {31'h0, Misalign},     32'd0);
    check("ma_pc",       IF_PC,                 32'h104);

    // Back-to-back redirects: last wins
    RedirectValid  = 1'b1;
    RedirectTarget = 32'h0000_0200;
    tick;
    RedirectTarget = 32'h0000_0300;
    tick;
    check("bb_addr",     Address,               32'h300);
    check("bb_valid",    {31'h0, IF_Valid},     32'd0);
    RedirectValid = 1'b0;
    tick;
    check("bb_pc",       IF_PC,                 32'h300);

    // PC+4 wrap at the top of the address space
    RedirectValid  = 1'b1;
    RedirectTarget = 32'hFFFF_FFFC;
    tick;
    RedirectValid = 1'b0;
    tick;
    check("wr_pc",       IF_PC,                 32'hFFFF_FFFC);
    check("wr_pcp4",     IF_PCPlus4,            32'h0);
    check("wr_addr",     Address,               32'h0);

    // JAL at 0xC with decode stalled
    ID_Ready       = 1'b0;
    RedirectValid  = 1'b1;
    RedirectTarget = 32'h0000_000C;
    tick;
    RedirectValid = 1'b0;
    tick;
    check("jal_pc",      IF_PC,                 32'hC);
    check("jal_inst",    IF_Instruction,        32'h0c10_006d);
    check("jal_next",    Address,               c_JAL_NEXT);
    check("jal_pred",    {31'h0, IF_PredTaken}, c_JAL_PRED);

    // Asynchronous reset with two entries queued
    tick;
    check("ar_pre_v",    {31'h0, IF_Valid},     32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("ar_valid",    {31'h0, IF_Valid},     32'd0);
    check("ar_addr",     Address,               32'h0);
    check("ar_pc",       IF_PC,                 32'h0);
    tick;
    reset    = 1'b1;
    ID_Ready = 1'b1;
    tick;
    check("ar_restart",  IF_PC,                 32'h0);
    check("ar_rvalid",   {31'h0, IF_Valid},     32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
